// File: rtl/fp_sgnj_arbiter_if.sv
// Request/result bundle for fp_sgnj_arbiter: two issue requesters in, one registered result out.
// slave is the arbiter side, master is the requester/writeback side.
interface fp_sgnj_arbiter_if #(
  parameter int unsigned TAG_W = 5
);
  logic [1:0]       in_req_valid;
  logic [1:0]       out_req_ready;
  logic [63:0]      in_numA0;
  logic [63:0]      in_numA1;
  logic [63:0]      in_numB0;
  logic [63:0]      in_numB1;
  logic [1:0]       in_ctrl_jnx0;
  logic [1:0]       in_ctrl_jnx1;
  logic             in_fmt0;
  logic             in_fmt1;
  logic [TAG_W-1:0] in_tag0;
  logic [TAG_W-1:0] in_tag1;
  logic             out_valid;
  logic             in_out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_src;

  modport slave (
    input  in_req_valid, in_numA0, in_numA1, in_numB0, in_numB1,
    input  in_ctrl_jnx0, in_ctrl_jnx1, in_fmt0, in_fmt1, in_tag0, in_tag1, in_out_ready,
    output out_req_ready, out_valid, out_data, out_tag, out_src
  );

  modport master (
    output in_req_valid, in_numA0, in_numA1, in_numB0, in_numB1,
    output in_ctrl_jnx0, in_ctrl_jnx1, in_fmt0, in_fmt1, in_tag0, in_tag1, in_out_ready,
    input  out_req_ready, out_valid, out_data, out_tag, out_src
  );
endinterface

// File: rtl/fp_sgnj_arbiter.sv
// Round-robin shared FSGNJ/FSGNJN/FSGNJX datapath (S and D) with a single registered result.
// Define FP_SGNJ_ARB_NANBOX_CHK_EN to replace improperly NaN-boxed single operands by canonical NaN.
module fp_sgnj_arbiter #(
  parameter int unsigned TAG_W = 5
) (
  input logic              in_clk,
  input logic              in_rst_n,
  fp_sgnj_arbiter_if.slave bus
);

  logic             ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;

  logic             slot_free;
  logic [1:0]       grant;
  logic [1:0]       req_ready;
  logic             xfer;
  logic             sel;

  logic [63:0]      sel_a, sel_b;
  logic [1:0]       sel_jnx;
  logic             sel_fmt;
  logic [TAG_W-1:0] sel_tag;
  logic [63:0]      op_a, op_b;
  logic             sign;
  logic [63:0]      result;

`ifdef FP_SGNJ_ARB_NANBOX_CHK_EN
  function automatic logic [63:0] nanbox_chk(input logic [63:0] op);
    logic [63:0] res;
    res = op;
    if (op[63:32] != 32'hFFFF_FFFF) begin
      res = {32'hFFFF_FFFF, 32'h7FC0_0000};
    end
    return res;
  endfunction
`endif

  // Arbitration: a lone requester always wins; on contention ptr decides.
  always_comb begin
    grant = 2'b00;
    unique case (bus.in_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Gated by reset so nothing counts as accepted while reset is held.
  assign slot_free = ~valid_q | bus.in_out_ready;
  assign req_ready = grant & {2{slot_free & in_rst_n}};
  assign xfer      = |req_ready;
  assign sel       = grant[1];

  assign bus.out_req_ready = req_ready;

  // Operand select
  always_comb begin
    sel_a   = sel ? bus.in_numA1     : bus.in_numA0;
    sel_b   = sel ? bus.in_numB1     : bus.in_numB0;
    sel_jnx = sel ? bus.in_ctrl_jnx1 : bus.in_ctrl_jnx0;
    sel_fmt = sel ? bus.in_fmt1      : bus.in_fmt0;
    sel_tag = sel ? bus.in_tag1      : bus.in_tag0;
  end

  // Sign-injection datapath
  always_comb begin
    op_a = sel_a;
    op_b = sel_b;
`ifdef FP_SGNJ_ARB_NANBOX_CHK_EN
    if (!sel_fmt) begin
      op_a = nanbox_chk(sel_a);
      op_b = nanbox_chk(sel_b);
    end
`endif
    sign = 1'b0;
    if (sel_fmt) begin
      unique case (sel_jnx)
        2'b00:   sign = op_b[63];
        2'b01:   sign = ~op_b[63];
        2'b10:   sign = op_a[63] ^ op_b[63];
        default: sign = op_a[63];
      endcase
      result = {sign, op_a[62:0]};
    end else begin
      unique case (sel_jnx)
        2'b00:   sign = op_b[31];
        2'b01:   sign = ~op_b[31];
        2'b10:   sign = op_a[31] ^ op_b[31];
        default: sign = op_a[31];
      endcase
      result = {32'hFFFF_FFFF, sign, op_a[30:0]};
    end
  end

  // Result register and pointer next state; drain and load may coincide.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    src_d   = src_q;
    if (xfer) begin
      ptr_d   = ~sel;
      valid_d = 1'b1;
      data_d  = result;
      tag_d   = sel_tag;
      src_d   = sel;
    end else if (valid_q && bus.in_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      ptr_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_src   = src_q;

endmodule
